// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: single-MAC KxK stride-1 no-padding 2-D convolution over a raster pixel stream
//   clk, rst                     clock (rising edge), asynchronous active-low reset
//   start, relu_en               begin one image (idle only); ReLU select latched at start
//   kern_we, kern_addr, kern_data kernel weight write (row-major ky*K+kx), accepted only when idle
//   pix_valid, pix_ready, pix_data input pixel stream, raster order
//   out_valid, out_ready, out_data, out_last result stream; last marks final result of image
//   busy, done                   image in progress; one-cycle pulse after final result handshake
module conv2d_stream_engine #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K = 3,
  parameter int DATA_W = 16,
  parameter int ACC_W = 40,
  localparam int KAW = K > 1 ? $clog2(K*K) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     kern_we,
  input  logic [KAW-1:0]           kern_addr,
  input  logic signed [DATA_W-1:0] kern_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int SW = K > 1 ? $clog2(K) : 1;
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, MAC = 3'd2, OUT = 3'd3, ROW = 3'd4, DONE = 3'd5;
  if (ACC_W < 2*DATA_W + $clog2(K*K)) begin : g_acc_chk
    $error("ACC_W too narrow for full-precision KxK accumulation");
  end
  logic [2:0] state_q, state_d;
  logic relu_q, relu_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [CW-1:0] col_q, col_d, ox_q, ox_d;
  logic [RW-1:0] oy_q, oy_d;
  logic [SW-1:0] rcnt_q, rcnt_d, top_q, top_d, kx_q, kx_d, ky_q, ky_d;
  logic [KAW-1:0] tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic signed [DATA_W-1:0] kern_q [K*K];
  logic signed [DATA_W-1:0] kern_d [K*K];
  logic signed [DATA_W-1:0] line_mem [K][IMG_W];
  logic pix_fire, col_end, tap_end;
  logic [SW:0] slot_sum;
  logic [SW-1:0] rd_slot, wr_slot;
  logic [CW-1:0] rd_col;
  logic signed [2*DATA_W-1:0] prod;
  assign pix_ready = state_q == FILL || state_q == ROW;
  assign pix_fire = pix_valid && pix_ready;
  assign col_end = col_q == CW'(IMG_W-1);
  assign tap_end = tap_q == KAW'(K*K-1);
  // Rows live in a circular set of K slots; top_q is the slot holding window row 0.
  assign slot_sum = {1'b0, top_q} + {1'b0, ky_q};
  assign rd_slot = slot_sum >= (SW+1)'(K) ? SW'(slot_sum - (SW+1)'(K)) : SW'(slot_sum);
  assign wr_slot = state_q == FILL ? rcnt_q : top_q;
  assign rd_col = ox_q + CW'(kx_q);
  assign prod = (2*DATA_W)'(line_mem[rd_slot][rd_col]) * (2*DATA_W)'(kern_q[tap_q]);
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    relu_d = relu_q;
    col_d = col_q;
    rcnt_d = rcnt_q;
    top_d = top_q;
    ox_d = ox_q;
    oy_d = oy_q;
    kx_d = kx_q;
    ky_d = ky_q;
    tap_d = tap_q;
    acc_d = acc_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    kern_d = kern_q;
    case (state_q)
      IDLE: begin
        if (kern_we && int'(kern_addr) < K*K) kern_d[kern_addr] = kern_data;
        if (start) begin
          state_d = FILL;
          relu_d = relu_en;
          col_d = '0;
          rcnt_d = '0;
          top_d = '0;
          ox_d = '0;
          oy_d = '0;
          kx_d = '0;
          ky_d = '0;
          tap_d = '0;
        end
      end
      FILL: if (pix_fire) begin
        col_d = col_end ? '0 : col_q + CW'(1);
        if (col_end) begin
          rcnt_d = rcnt_q + SW'(1);
          if (rcnt_q == SW'(K-1)) state_d = MAC;
        end
      end
      MAC: begin
        // First tap overwrites the accumulator so no separate clear cycle is needed.
        acc_d = (tap_q == '0 ? '0 : acc_q) + ACC_W'(prod);
        kx_d = kx_q == SW'(K-1) ? '0 : kx_q + SW'(1);
        ky_d = kx_q == SW'(K-1) ? ky_q + SW'(1) : ky_q;
        tap_d = tap_q + KAW'(1);
        if (tap_end) begin
          state_d = OUT;
          kx_d = '0;
          ky_d = '0;
          tap_d = '0;
        end
      end
      OUT: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d = relu_q && acc_q[ACC_W-1] ? '0 : acc_q;
        out_last_d = ox_q == CW'(OW-1) && oy_q == RW'(OH-1);
      end else if (out_ready) begin
        out_valid_d = 1'b0;
        out_last_d = 1'b0;
        if (ox_q != CW'(OW-1)) begin
          ox_d = ox_q + CW'(1);
          state_d = MAC;
        end else if (oy_q != RW'(OH-1)) begin
          col_d = '0;
          state_d = ROW;
        end else state_d = DONE;
      end
      ROW: if (pix_fire) begin
        col_d = col_end ? '0 : col_q + CW'(1);
        if (col_end) begin
          top_d = top_q == SW'(K-1) ? '0 : top_q + SW'(1);
          oy_d = oy_q + RW'(1);
          ox_d = '0;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      relu_q <= 1'b0;
      col_q <= '0;
      rcnt_q <= '0;
      top_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      kx_q <= '0;
      ky_q <= '0;
      tap_q <= '0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      kern_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      relu_q <= relu_d;
      col_q <= col_d;
      rcnt_q <= rcnt_d;
      top_q <= top_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      kx_q <= kx_d;
      ky_q <= ky_d;
      tap_q <= tap_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      kern_q <= kern_d;
    end
  end
  always_ff @(posedge clk) if (pix_fire) line_mem[wr_slot][col_q] <= pix_data;
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: directed checks of the 8x8 / 3x3 convolution engine
module tb_conv2d_stream_engine;
  localparam int W = 8, H = 8, K = 3, DW = 16, AW = 40, NR = 36, NP = 64;
  logic clk = 0, rst = 0, start = 0, relu_en = 0, kern_we = 0, pix_valid = 0, out_ready = 0;
  logic [3:0] kern_addr = 0;
  logic signed [DW-1:0] kern_data = 0, pix_data = 0;
  logic pix_ready, out_valid, out_last, busy, done;
  logic signed [AW-1:0] out_data;
  int errors = 0, checks = 0;
  int kw [9];
  logic signed [AW-1:0] got [NR];
  bit got_last [NR];
  int nres, done_cnt, done_gap, lat, stall_seen, stall_bad, timeout;
  logic ab_valid, ab_ready, ab_busy, ab_done, ab_last;
  logic signed [AW-1:0] ab_data;
  always #5 clk = ~clk;
  conv2d_stream_engine #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .kern_we(kern_we),
    .kern_addr(kern_addr), .kern_data(kern_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      kern_we = 1;
      kern_addr = 4'(i);
      kern_data = DW'(kw[i]);
    end
    @(negedge clk);
    kern_we = 0;
  endtask
  // Streams pixel p = r*8+c and collects results; all observations at negedges.
  task automatic run_image(input bit rel, input bit gaps, input int stall_at, input int abort_at, input bit inject);
    int pi = 0, cyc = 0, last_pix = -1, first_out = -1, last_out = -1, done_at = -1;
    logic signed [AW-1:0] held = 0;
    nres = 0; done_cnt = 0; stall_seen = 0; stall_bad = 0; timeout = 0;
    @(negedge clk);
    start = 1;
    relu_en = rel;
    @(negedge clk);
    start = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      kern_we = 0;
      start = 0;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      if (cyc > 4000) begin
        timeout = 1;
        break;
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (abort_at >= 0 && nres == abort_at && out_valid) begin
        rst = 0;
        #1;
        ab_valid = out_valid; ab_ready = pix_ready; ab_busy = busy;
        ab_done = done; ab_last = out_last; ab_data = out_data;
        break;
      end
      if (inject && (pi == 10 || (nres == 3 && out_valid))) begin
        kern_we = 1;
        kern_addr = 0;
        kern_data = 100;
        start = 1;
      end
      if (nres == stall_at && stall_seen < 5 && (out_valid || stall_seen > 0)) begin
        if (stall_seen == 0) held = out_data;
        if (out_valid !== 1'b1 || out_data !== held || pix_ready !== 1'b0) stall_bad++;
        stall_seen++;
        out_ready = 0;
      end else out_ready = 1;
      pix_valid = pi < NP && (!gaps || $urandom_range(0, 1) == 1);
      pix_data = DW'(pi);
      if (pix_valid && pix_ready) begin
        if (pi == K*W - 1) last_pix = cyc;
        pi++;
      end
      if (out_valid && out_ready) begin
        if (nres < NR) begin
          got[nres] = out_data;
          got_last[nres] = out_last;
        end
        nres++;
        last_out = cyc;
      end
    end
    pix_valid = 0;
    out_ready = 0;
    // Pixel accepted at the edge after sample n enters MAC; out_valid rises K*K+1 edges later.
    lat = first_out - last_pix;
    done_gap = done_at - last_out;
  endtask
  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
    rst = 1;
    @(negedge clk);
  endtask
  task automatic test_conv();
    kw = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    load_kernel();
    run_image(0, 0, -1, -1, 0);
    checks++; if (nres != NR || timeout) begin errors++; $display("FAIL conv_count got=%0d timeout=%0d exp=%0d", nres, timeout, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (got[i] !== AW'(48) || got_last[i] !== (i == NR-1)) begin
        errors++; $display("FAIL conv_r%0d got=%0d last=%b exp=48 last=%b", i, got[i], got_last[i], i == NR-1);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL conv_done_width got=%0d exp=1", done_cnt); end
    checks++; if (done_gap != 1) begin errors++; $display("FAIL conv_done_gap got=%0d exp=1", done_gap); end
    checks++; if (lat != K*K+2) begin errors++; $display("FAIL conv_latency got=%0d exp=%0d", lat, K*K+2); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conv_busy_after got=%b exp=0", busy); end
  endtask
  task automatic test_mapping();
    logic signed [AW-1:0] exp_v;
    kw = '{0, -1, 0, 0, 0, 0, 2, 0, 0};
    load_kernel();
    run_image(0, 0, -1, -1, 0);
    checks++; if (nres != NR || timeout) begin errors++; $display("FAIL map_count got=%0d exp=%0d", nres, NR); end
    for (int oy = 0; oy < 6; oy++)
      for (int ox = 0; ox < 6; ox++) begin
        exp_v = AW'(8*oy + ox + 31);
        checks++;
        if (got[oy*6+ox] !== exp_v) begin
          errors++; $display("FAIL map_y%0d_x%0d got=%0d exp=%0d", oy, ox, got[oy*6+ox], exp_v);
        end
      end
  endtask
  task automatic test_relu();
    kw = '{1, 1, 1, 0, 0, 0, -1, -1, -1};
    load_kernel();
    run_image(1, 0, -1, -1, 0);
    checks++; if (nres != NR) begin errors++; $display("FAIL relu_on_count got=%0d exp=%0d", nres, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== '0) begin errors++; $display("FAIL relu_on_r%0d got=%0d exp=0", i, got[i]); end
    end
    run_image(0, 0, -1, -1, 0);
    checks++; if (nres != NR) begin errors++; $display("FAIL relu_off_count got=%0d exp=%0d", nres, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== AW'(-48)) begin errors++; $display("FAIL relu_off_r%0d got=%0d exp=-48", i, got[i]); end
    end
  endtask
  task automatic test_backpressure();
    kw = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    load_kernel();
    run_image(0, 0, 6, -1, 0);
    checks++; if (stall_seen != 5 || stall_bad != 0) begin errors++; $display("FAIL stall_hold seen=%0d bad=%0d exp seen=5 bad=0", stall_seen, stall_bad); end
    checks++; if (nres != NR) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", nres, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== AW'(48)) begin errors++; $display("FAIL stall_r%0d got=%0d exp=48", i, got[i]); end
    end
  endtask
  task automatic test_gaps();
    run_image(0, 1, -1, -1, 0);
    checks++; if (nres != NR || done_cnt != 1) begin errors++; $display("FAIL gaps_count got=%0d done=%0d exp=%0d done=1", nres, done_cnt, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (got[i] !== AW'(48) || got_last[i] !== (i == NR-1)) begin
        errors++; $display("FAIL gaps_r%0d got=%0d last=%b exp=48", i, got[i], got_last[i]);
      end
    end
  endtask
  task automatic test_midreset();
    int dh = 0;
    run_image(0, 0, -1, 19, 0);
    checks++; if (ab_valid !== 1'b0 || ab_data !== '0 || ab_last !== 1'b0) begin errors++; $display("FAIL abort_out got valid=%b data=%0d last=%b exp 0 0 0", ab_valid, ab_data, ab_last); end
    checks++; if (ab_busy !== 1'b0 || ab_ready !== 1'b0 || ab_done !== 1'b0) begin errors++; $display("FAIL abort_ctl got busy=%b ready=%b done=%b exp 0 0 0", ab_busy, ab_ready, ab_done); end
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid) dh++;
    end
    checks++; if (dh != 0) begin errors++; $display("FAIL abort_no_output got=%0d exp=0", dh); end
    run_image(0, 0, -1, -1, 0);
    checks++; if (nres != NR) begin errors++; $display("FAIL zero_kern_count got=%0d exp=%0d", nres, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== '0) begin errors++; $display("FAIL zero_kern_r%0d got=%0d exp=0", i, got[i]); end
    end
    kw = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    load_kernel();
    run_image(0, 0, -1, -1, 0);
    checks++; if (nres != NR) begin errors++; $display("FAIL rerun_count got=%0d exp=%0d", nres, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== AW'(48)) begin errors++; $display("FAIL rerun_r%0d got=%0d exp=48", i, got[i]); end
    end
  endtask
  task automatic test_busy_ignore();
    run_image(0, 0, -1, -1, 1);
    checks++; if (nres != NR || done_cnt != 1) begin errors++; $display("FAIL busy_ign_count got=%0d done=%0d exp=%0d done=1", nres, done_cnt, NR); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (got[i] !== AW'(48)) begin errors++; $display("FAIL busy_ign_r%0d got=%0d exp=48", i, got[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_conv();
    test_mapping();
    test_relu();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
